// File: rtl/cci_mpf_sim_pkg.sv
// Shared CCI simulation types for the FIU-side memory responder and its
// request FIFOs.
package cci_mpf_sim_pkg;

  localparam int unsigned CCI_CLADDR_WIDTH     = 42;
  localparam int unsigned CCI_CLDATA_WIDTH     = 512;
  localparam int unsigned CCI_MDATA_WIDTH      = 16;
  localparam int unsigned CCI_AF_SLACK_DEFAULT = 4;

  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;
  typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_clData;
  typedef logic [CCI_MDATA_WIDTH-1:0]  t_cci_mdata;

  typedef struct packed {
    t_cci_clAddr addr;
    t_cci_mdata  mdata;
  } t_rd_req;

  typedef struct packed {
    t_cci_clAddr addr;
    t_cci_clData data;
    t_cci_mdata  mdata;
  } t_wr_req;

endpackage

// File: rtl/cci_mpf_fiu_resp_req_fifo.sv
// Circular request FIFO with occupancy count, registered almost_full and a
// sticky overflow flag. A push onto a full FIFO is dropped unless a pop
// happens in the same cycle.
module cci_mpf_fiu_resp_req_fifo #(
  parameter type         T        = logic,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_SLACK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enq,
  input  T     i_enq_data,
  input  logic i_deq,
  output T     o_head,
  output logic o_empty,
  output logic o_almost_full,
  output logic o_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_almost_full;
  logic             r_overflow;

  logic             w_full;
  logic             w_do_deq;
  logic             w_do_enq;
  logic [CNT_W-1:0] w_count_nxt;

  assign o_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_do_deq = i_deq && !o_empty;
  assign w_do_enq = i_enq && (!w_full || w_do_deq);

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_enq && !w_do_deq)
      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_do_enq && w_do_deq)
      w_count_nxt = r_count - CNT_W'(1);
  end

  // Pointers, count, almost_full and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count       <= w_count_nxt;
      r_almost_full <= (w_count_nxt >= CNT_W'(DEPTH - AF_SLACK));
      if (i_enq && !w_do_enq) r_overflow <= 1'b1;
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_wr_ptr] <= i_enq_data;
  end

  assign o_head        = r_mem[r_rd_ptr];
  assign o_almost_full = r_almost_full;
  assign o_overflow    = r_overflow;

endmodule

// File: rtl/cci_mpf_fiu_mem_responder.sv
// FIU-side memory responder: queues c0 reads and c1 writes, services them
// from an on-chip line memory and returns fixed-latency responses that echo
// Mdata.
module cci_mpf_fiu_mem_responder
  import cci_mpf_sim_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 42,
  parameter int unsigned MDATA_WIDTH    = 16,
  parameter int unsigned MEM_IDX_BITS   = 8,
  parameter int unsigned REQ_FIFO_DEPTH = 16,
  parameter int unsigned AF_SLACK       = CCI_AF_SLACK_DEFAULT,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned WR_LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   c0_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c0_req_addr,
  input  logic [MDATA_WIDTH-1:0] c0_req_mdata,
  output logic                   c0_almost_full,
  input  logic                   c1_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c1_req_addr,
  input  logic [511:0]           c1_req_data,
  input  logic [MDATA_WIDTH-1:0] c1_req_mdata,
  output logic                   c1_almost_full,
  output logic                   c0_rsp_valid,
  output logic [511:0]           c0_rsp_data,
  output logic [MDATA_WIDTH-1:0] c0_rsp_mdata,
  output logic                   c1_rsp_valid,
  output logic [MDATA_WIDTH-1:0] c1_rsp_mdata,
  output logic                   overflow_err
);

  localparam int unsigned MEM_LINES = 2 ** MEM_IDX_BITS;

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;

  t_rd_req     w_rd_in;
  t_rd_req     w_rd_head;
  logic        w_rd_empty;
  logic        w_rd_ovf;
  logic        w_rd_deq_en;
  logic        w_rd_fire;

  t_wr_req     w_wr_in;
  t_wr_req     w_wr_head;
  logic        w_wr_empty;
  logic        w_wr_ovf;
  logic        w_wr_deq_en;
  logic        w_wr_fire;

  logic [MEM_IDX_BITS-1:0] w_rd_idx;
  logic [MEM_IDX_BITS-1:0] w_wr_idx;
  t_cci_clData             w_rd_mem_data;
  t_cci_clData             r_mem [MEM_LINES];

  logic        r_rd_vld   [RD_LATENCY];
  t_cci_clData r_rd_data  [RD_LATENCY];
  t_cci_mdata  r_rd_mdata [RD_LATENCY];
  logic        r_wr_vld   [WR_LATENCY];
  t_cci_mdata  r_wr_mdata [WR_LATENCY];

  logic        w_unused_addr_hi;

  // Reset: asynchronous assert, deassert synchronised to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Dequeue enables are a fixed stall point that can be overridden from a
  // debug harness; in normal operation each FIFO drains whenever non-empty.
  assign w_rd_deq_en = 1'b1;
  assign w_wr_deq_en = 1'b1;
  assign w_rd_fire   = w_rd_deq_en && !w_rd_empty;
  assign w_wr_fire   = w_wr_deq_en && !w_wr_empty;

  assign w_rd_in.addr  = t_cci_clAddr'(c0_req_addr);
  assign w_rd_in.mdata = t_cci_mdata'(c0_req_mdata);
  assign w_wr_in.addr  = t_cci_clAddr'(c1_req_addr);
  assign w_wr_in.data  = c1_req_data;
  assign w_wr_in.mdata = t_cci_mdata'(c1_req_mdata);

  cci_mpf_fiu_resp_req_fifo #(
    .T        (t_rd_req),
    .DEPTH    (REQ_FIFO_DEPTH),
    .AF_SLACK (AF_SLACK)
  ) u_rd_fifo (
    .clk           (clk),
    .rst_n         (w_rst_n),
    .i_enq         (c0_req_valid),
    .i_enq_data    (w_rd_in),
    .i_deq         (w_rd_fire),
    .o_head        (w_rd_head),
    .o_empty       (w_rd_empty),
    .o_almost_full (c0_almost_full),
    .o_overflow    (w_rd_ovf)
  );

  cci_mpf_fiu_resp_req_fifo #(
    .T        (t_wr_req),
    .DEPTH    (REQ_FIFO_DEPTH),
    .AF_SLACK (AF_SLACK)
  ) u_wr_fifo (
    .clk           (clk),
    .rst_n         (w_rst_n),
    .i_enq         (c1_req_valid),
    .i_enq_data    (w_wr_in),
    .i_deq         (w_wr_fire),
    .o_head        (w_wr_head),
    .o_empty       (w_wr_empty),
    .o_almost_full (c1_almost_full),
    .o_overflow    (w_wr_ovf)
  );

  // Only the low index bits select a line; higher address bits alias.
  assign w_rd_idx         = w_rd_head.addr[MEM_IDX_BITS-1:0];
  assign w_wr_idx         = w_wr_head.addr[MEM_IDX_BITS-1:0];
  assign w_unused_addr_hi = ^{w_rd_head.addr[CCI_CLADDR_WIDTH-1:MEM_IDX_BITS],
                              w_wr_head.addr[CCI_CLADDR_WIDTH-1:MEM_IDX_BITS]};

  // Read samples the array before this cycle's write lands, so a same-cycle
  // read of the written line returns the old contents.
  assign w_rd_mem_data = r_mem[w_rd_idx];

  // Line memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[w_wr_idx] <= w_wr_head.data;
  end

  // Read response pipe: stage 0 loads at dequeue, output is the last stage.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        r_rd_vld[i]   <= 1'b0;
        r_rd_data[i]  <= '0;
        r_rd_mdata[i] <= '0;
      end
    end else begin
      r_rd_vld[0]   <= w_rd_fire;
      r_rd_data[0]  <= w_rd_mem_data;
      r_rd_mdata[0] <= w_rd_head.mdata;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_rd_vld[i]   <= r_rd_vld[i-1];
        r_rd_data[i]  <= r_rd_data[i-1];
        r_rd_mdata[i] <= r_rd_mdata[i-1];
      end
    end
  end

  // Write response pipe carrying only the valid and Mdata.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned i = 0; i < WR_LATENCY; i++) begin
        r_wr_vld[i]   <= 1'b0;
        r_wr_mdata[i] <= '0;
      end
    end else begin
      r_wr_vld[0]   <= w_wr_fire;
      r_wr_mdata[0] <= w_wr_head.mdata;
      for (int unsigned i = 1; i < WR_LATENCY; i++) begin
        r_wr_vld[i]   <= r_wr_vld[i-1];
        r_wr_mdata[i] <= r_wr_mdata[i-1];
      end
    end
  end

  assign c0_rsp_valid = r_rd_vld[RD_LATENCY-1];
  assign c0_rsp_data  = r_rd_data[RD_LATENCY-1];
  assign c0_rsp_mdata = MDATA_WIDTH'(r_rd_mdata[RD_LATENCY-1]);
  assign c1_rsp_valid = r_wr_vld[WR_LATENCY-1];
  assign c1_rsp_mdata = MDATA_WIDTH'(r_wr_mdata[WR_LATENCY-1]);
  assign overflow_err = w_rd_ovf | w_wr_ovf;

endmodule

// File: tb/tb_cci_mpf_fiu_mem_responder.sv
// Self-checking bench for cci_mpf_fiu_mem_responder: a line-memory model,
// response monitors and per-feature scenario tasks.
module tb_cci_mpf_fiu_mem_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;
  localparam int DEPTH  = 16;
  localparam int SLACK  = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         c0_req_valid = 1'b0;
  logic [41:0]  c0_req_addr = '0;
  logic [15:0]  c0_req_mdata = '0;
  logic         c0_almost_full;
  logic         c1_req_valid = 1'b0;
  logic [41:0]  c1_req_addr = '0;
  logic [511:0] c1_req_data = '0;
  logic [15:0]  c1_req_mdata = '0;
  logic         c1_almost_full;
  logic         c0_rsp_valid;
  logic [511:0] c0_rsp_data;
  logic [15:0]  c0_rsp_mdata;
  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;
  logic         overflow_err;

  cci_mpf_fiu_mem_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .c0_req_valid   (c0_req_valid),
    .c0_req_addr    (c0_req_addr),
    .c0_req_mdata   (c0_req_mdata),
    .c0_almost_full (c0_almost_full),
    .c1_req_valid   (c1_req_valid),
    .c1_req_addr    (c1_req_addr),
    .c1_req_data    (c1_req_data),
    .c1_req_mdata   (c1_req_mdata),
    .c1_almost_full (c1_almost_full),
    .c0_rsp_valid   (c0_rsp_valid),
    .c0_rsp_data    (c0_rsp_data),
    .c0_rsp_mdata   (c0_rsp_mdata),
    .c1_rsp_valid   (c1_rsp_valid),
    .c1_rsp_mdata   (c1_rsp_mdata),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int           cyc;
    logic [15:0]  md;
    logic [511:0] d;
  } rsp_t;

  rsp_t rd_q[$];
  rsp_t wr_q[$];

  logic [511:0] mem_m [256];
  logic [41:0]  addrs [20];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (c0_rsp_valid === 1'b1) rd_q.push_back('{cyc, c0_rsp_mdata, c0_rsp_data});
    if (c1_rsp_valid === 1'b1) wr_q.push_back('{cyc, c1_rsp_mdata, '0});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input bit rv, input logic [41:0] ra, input logic [15:0] rm,
                       input bit wv, input logic [41:0] wa, input logic [511:0] wd,
                       input logic [15:0] wm);
    @(negedge clk);
    c0_req_valid = rv; c0_req_addr = ra; c0_req_mdata = rm;
    c1_req_valid = wv; c1_req_addr = wa; c1_req_data = wd; c1_req_mdata = wm;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cycles(4);
    reset_n = 1'b1;
    wait_cycles(4);
    n_checks++;
    if ({c0_rsp_valid, c1_rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b required 00", {c0_rsp_valid, c1_rsp_valid});
    end
    n_checks++;
    if ({c0_almost_full, c1_almost_full, overflow_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {c0_almost_full, c1_almost_full, overflow_err});
    end
    n_checks++;
    if ({c0_rsp_data, c0_rsp_mdata, c1_rsp_mdata} !== '0) begin
      n_fail++; $display("FAIL reset_rsp_fields: got nonzero data/mdata %h %h %h", c0_rsp_data, c0_rsp_mdata, c1_rsp_mdata);
    end
  endtask

  task automatic test_basic();
    int t;
    logic [511:0] a5;
    for (int i = 0; i < 64; i++) a5[i*8 +: 8] = 8'hA5;
    rd_q.delete(); wr_q.delete();
    drive(1'b0, '0, '0, 1'b1, 42'h5, a5, 16'h11);
    t = cyc;
    idle();
    wait_cycles(8);
    mem_m[8'h05] = a5;
    n_checks++;
    if (wr_q.size() !== 1) begin
      n_fail++; $display("FAIL basic_wr_count: got %0d required 1", wr_q.size());
    end else begin
      n_checks++;
      if (wr_q[0].cyc - t !== WR_LAT + 1) begin
        n_fail++; $display("FAIL basic_wr_latency: got %0d required %0d", wr_q[0].cyc - t, WR_LAT + 1);
      end
      n_checks++;
      if (wr_q[0].md !== 16'h11) begin
        n_fail++; $display("FAIL basic_wr_mdata: got %h required 0011", wr_q[0].md);
      end
    end
    drive(1'b1, 42'h5, 16'h22, 1'b0, '0, '0, '0);
    t = cyc;
    idle();
    wait_cycles(8);
    n_checks++;
    if (rd_q.size() !== 1) begin
      n_fail++; $display("FAIL basic_rd_count: got %0d required 1", rd_q.size());
    end else begin
      n_checks++;
      if (rd_q[0].cyc - t !== RD_LAT + 1) begin
        n_fail++; $display("FAIL basic_rd_latency: got %0d required %0d", rd_q[0].cyc - t, RD_LAT + 1);
      end
      n_checks++;
      if ({rd_q[0].md, rd_q[0].d} !== {16'h22, a5}) begin
        n_fail++; $display("FAIL basic_rd_data: got md %h data %h required md 0022 data %h", rd_q[0].md, rd_q[0].d, a5);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int sent, slack, occ, iter;
    bit stalled, af, exp_af, send, deq, enq, saw_af;
    logic [511:0] d;
    rd_q.delete(); wr_q.delete();
    // 20 back-to-back random writes; addresses are random 42-bit values.
    for (int i = 0; i < 20; i++) begin
      addrs[i] = {$urandom, $urandom};
      d = rand_line();
      mem_m[addrs[i][7:0]] = d;
      drive(1'b0, '0, '0, 1'b1, addrs[i], d, 16'(i));
      if (i == 0) t0 = cyc;
    end
    idle();
    wait_cycles(10);
    n_checks++;
    if (wr_q.size() !== 20) begin
      n_fail++; $display("FAIL b2b_wr_count: got %0d required 20", wr_q.size());
    end
    for (int i = 0; i < 20 && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i].md !== 16'(i) || wr_q[i].cyc - t0 !== i + WR_LAT + 1) begin
        n_fail++; $display("FAIL b2b_wr_%0d: got md %h at +%0d required md %h at +%0d",
                           i, wr_q[i].md, wr_q[i].cyc - t0, 16'(i), i + WR_LAT + 1);
      end
    end
    // Reads with the drain stalled so the FIFO fills; sender honours AF.
    force dut.w_rd_deq_en = 1'b0;
    stalled = 1; sent = 0; slack = 0; occ = 0; iter = 0; exp_af = 0; saw_af = 0;
    while (sent < 20 && iter < 200) begin
      @(negedge clk);
      af = c0_almost_full;
      if (af) saw_af = 1;
      n_checks++;
      if (af !== exp_af) begin
        n_fail++; $display("FAIL b2b_af_iter%0d: got %b required %b (occupancy %0d)", iter, af, exp_af, occ);
      end
      if (iter == 18) begin
        release dut.w_rd_deq_en;
        stalled = 0;
      end
      if (!af) slack = 0;
      send = !af || (slack < SLACK);
      if (af && send) slack++;
      c0_req_valid = send;
      c0_req_addr  = addrs[sent];
      c0_req_mdata = 16'(sent);
      deq = !stalled && (occ > 0);
      enq = send && ((occ < DEPTH) || deq);
      if (send) sent++;
      occ = occ + int'(enq) - int'(deq);
      exp_af = (occ >= DEPTH - SLACK);
      iter++;
    end
    n_checks++;
    if (sent !== 20) begin
      n_fail++; $display("FAIL b2b_send_budget: got %0d sent required 20", sent);
    end
    idle();
    if (stalled) release dut.w_rd_deq_en;
    wait_cycles(40);
    n_checks++;
    if (saw_af !== 1'b1) begin
      n_fail++; $display("FAIL b2b_af_seen: got %b required 1", saw_af);
    end
    n_checks++;
    if (overflow_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_overflow: got %b required 0", overflow_err);
    end
    n_checks++;
    if (rd_q.size() !== 20) begin
      n_fail++; $display("FAIL b2b_rd_count: got %0d required 20", rd_q.size());
    end
    for (int i = 0; i < 20 && i < rd_q.size(); i++) begin
      n_checks++;
      if (rd_q[i].md !== 16'(i) || rd_q[i].d !== mem_m[addrs[i][7:0]]) begin
        n_fail++; $display("FAIL b2b_rd_%0d: got md %h data %h required md %h data %h",
                           i, rd_q[i].md, rd_q[i].d, 16'(i), mem_m[addrs[i][7:0]]);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [511:0] old_d, new_d;
    old_d = 512'h1;
    new_d = 512'h2;
    drive(1'b0, '0, '0, 1'b1, 42'h7, old_d, 16'h70);
    idle();
    wait_cycles(6);
    rd_q.delete(); wr_q.delete();
    drive(1'b1, 42'h7, 16'h71, 1'b1, 42'h7, new_d, 16'h72);
    drive(1'b1, 42'h7, 16'h73, 1'b0, '0, '0, '0);
    idle();
    wait_cycles(10);
    mem_m[8'h07] = new_d;
    n_checks++;
    if (rd_q.size() !== 2) begin
      n_fail++; $display("FAIL same_cycle_count: got %0d required 2", rd_q.size());
    end else begin
      n_checks++;
      if ({rd_q[0].md, rd_q[0].d} !== {16'h71, old_d}) begin
        n_fail++; $display("FAIL same_cycle_old: got md %h data %h required md 0071 data %h", rd_q[0].md, rd_q[0].d, old_d);
      end
      n_checks++;
      if ({rd_q[1].md, rd_q[1].d} !== {16'h73, new_d}) begin
        n_fail++; $display("FAIL same_cycle_new: got md %h data %h required md 0073 data %h", rd_q[1].md, rd_q[1].d, new_d);
      end
    end
  endtask

  task automatic test_alias();
    logic [511:0] d;
    d = 512'hBEEF;
    drive(1'b0, '0, '0, 1'b1, 42'h100, d, 16'h80);
    idle();
    wait_cycles(6);
    mem_m[8'h00] = d;
    rd_q.delete();
    drive(1'b1, 42'h000, 16'h81, 1'b0, '0, '0, '0);
    idle();
    wait_cycles(8);
    n_checks++;
    if (rd_q.size() !== 1) begin
      n_fail++; $display("FAIL alias_count: got %0d required 1", rd_q.size());
    end else begin
      n_checks++;
      if ({rd_q[0].md, rd_q[0].d} !== {16'h81, d}) begin
        n_fail++; $display("FAIL alias_data: got md %h data %h required md 0081 data %h", rd_q[0].md, rd_q[0].d, d);
      end
    end
  endtask

  task automatic test_overflow();
    rd_q.delete();
    force dut.w_rd_deq_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        n_checks++;
        if (overflow_err !== 1'b0) begin
          n_fail++; $display("FAIL ovf_before_17th: got %b required 0", overflow_err);
        end
      end
      c0_req_valid = 1'b1;
      c0_req_addr  = addrs[i];
      c0_req_mdata = 16'(100 + i);
    end
    idle();
    n_checks++;
    if ({overflow_err, c0_almost_full} !== 2'b11) begin
      n_fail++; $display("FAIL ovf_set: got ovf/af %b required 11", {overflow_err, c0_almost_full});
    end
    release dut.w_rd_deq_en;
    wait_cycles(40);
    n_checks++;
    if (overflow_err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflow_err);
    end
    n_checks++;
    if (rd_q.size() !== 16) begin
      n_fail++; $display("FAIL ovf_rsp_count: got %0d required 16", rd_q.size());
    end
    for (int i = 0; i < 16 && i < rd_q.size(); i++) begin
      n_checks++;
      if (rd_q[i].md !== 16'(100 + i) || rd_q[i].d !== mem_m[addrs[i][7:0]]) begin
        n_fail++; $display("FAIL ovf_rsp_%0d: got md %h data %h required md %h data %h",
                           i, rd_q[i].md, rd_q[i].d, 16'(100 + i), mem_m[addrs[i][7:0]]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    rd_q.delete(); wr_q.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, addrs[i], 16'(200 + i), 1'b0, '0, '0, '0);
    idle();
    wait_cycles(2);
    n_checks++;
    if ({c0_rsp_valid, c0_rsp_mdata} !== {1'b1, 16'd200}) begin
      n_fail++; $display("FAIL midrst_first_rsp: got valid %b md %h required 1 00c8", c0_rsp_valid, c0_rsp_mdata);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({c0_rsp_valid, c1_rsp_valid, c0_almost_full, c1_almost_full, overflow_err} !== 5'b0) begin
      n_fail++; $display("FAIL midrst_flags: got %b required 00000",
                         {c0_rsp_valid, c1_rsp_valid, c0_almost_full, c1_almost_full, overflow_err});
    end
    n_checks++;
    if ({c0_rsp_data, c0_rsp_mdata, c1_rsp_mdata} !== '0) begin
      n_fail++; $display("FAIL midrst_fields: got data %h md %h/%h required 0", c0_rsp_data, c0_rsp_mdata, c1_rsp_mdata);
    end
    rd_q.delete(); wr_q.delete();
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(25);
    n_checks++;
    if (rd_q.size() + wr_q.size() !== 0) begin
      n_fail++; $display("FAIL midrst_no_rsp: got %0d responses required 0", rd_q.size() + wr_q.size());
    end
    drive(1'b1, addrs[0], 16'h12C, 1'b0, '0, '0, '0);
    idle();
    wait_cycles(8);
    n_checks++;
    if (rd_q.size() !== 1) begin
      n_fail++; $display("FAIL midrst_mem_count: got %0d required 1", rd_q.size());
    end else begin
      n_checks++;
      if ({rd_q[0].md, rd_q[0].d} !== {16'h12C, mem_m[addrs[0][7:0]]}) begin
        n_fail++; $display("FAIL midrst_mem_kept: got md %h data %h required md 012c data %h",
                           rd_q[0].md, rd_q[0].d, mem_m[addrs[0][7:0]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_same_cycle();
    test_alias();
    test_overflow();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
